// File: rtl/fantasticfft_pkg.sv
// Shared types and helpers for the FFT input loader.
// Holds the loader state encoding, default sizes and a bit-reversal helper.
package fantasticfft_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int LOG2_N     = 4;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

  // Reverses the low 'width' bits of v; bits above 'width' come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fantasticfft_input_loader_if.sv
// Sample stream, RAM write port and frame handoff signals of the input loader.
// master = upstream/FFT side, slave = loader.
interface fantasticfft_input_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read_write;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_drive;
  logic                  frame_valid;
  logic                  frame_ack;
  logic                  frame_err;

  modport master (
    output in_valid, in_data, in_last, frame_ack,
    input  in_ready, mem_addr, mem_read_write, mem_wdata, mem_drive,
           frame_valid, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, frame_ack,
    output in_ready, mem_addr, mem_read_write, mem_wdata, mem_drive,
           frame_valid, frame_err
  );
endinterface

// File: rtl/fantasticfft_bitrev.sv
// Combinational bit reversal of a WIDTH-bit index.
module fantasticfft_bitrev
  import fantasticfft_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [31:0] rev_full;

  assign rev_full = bitrev(32'(din), WIDTH);
  assign dout     = rev_full[WIDTH-1:0];

endmodule

// File: rtl/fantasticfft_input_loader.sv
// Writes each N-sample frame into the FFT RAM at bit-reversed addresses,
// zero-pads short frames and hands the frame to the FFT core.
//
//   state | meaning
//   FILL  | accepting samples, one write per accepted sample
//   PAD   | early in_last seen, writing zeros up to idx N-1
//   HOLD  | frame resident in RAM, waiting for frame_ack
module fantasticfft_input_loader
  import fantasticfft_pkg::*;
#(
  parameter int DATA_WIDTH = fantasticfft_pkg::DATA_WIDTH,
  parameter int LOG2_N     = fantasticfft_pkg::LOG2_N,
  parameter int ADDR_WIDTH = fantasticfft_pkg::ADDR_WIDTH
) (
  input logic                    clk,
  input logic                    reset,
  fantasticfft_input_loader_if.slave bus
);

  localparam logic [LOG2_N-1:0] IDX_LAST = '1;

  loader_state_t         state_q, state_d;
  logic [LOG2_N-1:0]     idx_q, idx_d, idx_rev;
  logic                  accept;
  logic                  wr_d, err_d, fv_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_rw_q, frame_valid_q, frame_err_q;

  fantasticfft_bitrev #(.WIDTH(LOG2_N)) u_bitrev (
    .din  (idx_q),
    .dout (idx_rev)
  );

  assign bus.in_ready       = (state_q == FILL) && !reset;
  assign accept             = bus.in_valid && bus.in_ready;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_read_write = mem_rw_q;
  assign bus.mem_drive      = mem_rw_q;
  assign bus.frame_valid    = frame_valid_q;
  assign bus.frame_err      = frame_err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = 1'b0;
    wdata_d = bus.in_data;
    err_d   = 1'b0;
    // An ack only counts once frame_valid is visible to the core.
    fv_d    = (state_q == HOLD) && !(frame_valid_q && bus.frame_ack);
    unique case (state_q)
      FILL: begin
        if (accept) begin
          wr_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = HOLD;
            err_d   = !bus.in_last;
          end else begin
            idx_d = idx_q + LOG2_N'(1);
            if (bus.in_last) begin
              err_d   = 1'b1;
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        wr_d    = 1'b1;
        wdata_d = '0;
        if (idx_q == IDX_LAST) state_d = HOLD;
        else                   idx_d   = idx_q + LOG2_N'(1);
      end
      HOLD: begin
        if (frame_valid_q && bus.frame_ack) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      idx_q         <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_rw_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mem_rw_q      <= wr_d;
      frame_valid_q <= fv_d;
      frame_err_q   <= err_d;
      if (wr_d) begin
        mem_addr_q  <= ADDR_WIDTH'(idx_rev);
        mem_wdata_q <= wdata_d;
      end
    end
  end

endmodule

// File: tb/tb_fantasticfft_input_loader.sv
// Randomised frame stimulus for the input loader, checked cycle by cycle
// against a frame-level model: expected (addr, data) per write slot.
module tb_fantasticfft_input_loader;
  import fantasticfft_pkg::*;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int N  = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fantasticfft_input_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fantasticfft_input_loader #(.DATA_WIDTH(DW), .LOG2_N(LN), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int exp_last_addr = 0;
  int exp_last_data = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference bit reversal: read the index bits LSB-first into an MSB-first number.
  function automatic int rev(input int i);
    int r = 0;
    for (int b = 0; b < LN; b++) r = r * 2 + ((i >> b) & 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_rw"},    32'(bus.mem_read_write), 0);
    check_val({tag, "_drive"}, 32'(bus.mem_drive), 0);
    check_val({tag, "_addr"},  32'(bus.mem_addr), 32'(exp_last_addr));
    check_val({tag, "_data"},  32'(bus.mem_wdata), 32'(exp_last_data));
  endtask

  task automatic check_write(input string tag, input int addr, input int data);
    check_val({tag, "_rw"},    32'(bus.mem_read_write), 1);
    check_val({tag, "_drive"}, 32'(bus.mem_drive), 1);
    check_val({tag, "_addr"},  32'(bus.mem_addr), 32'(addr));
    check_val({tag, "_data"},  32'(bus.mem_wdata), 32'(data));
    exp_last_addr = addr;
    exp_last_data = data;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_addr",  32'(bus.mem_addr), 0);
    check_val("rst_rw",    32'(bus.mem_read_write), 0);
    check_val("rst_drive", 32'(bus.mem_drive), 0);
    check_val("rst_wdata", 32'(bus.mem_wdata), 0);
    check_val("rst_fv",    32'(bus.frame_valid), 0);
    check_val("rst_err",   32'(bus.frame_err), 0);
    exp_last_addr = 0;
    exp_last_data = 0;
  endtask

  // nsamp samples, in_last on the final one if nsamp < N or mark_last.
  // mode: 0 random data, 1 data = index, 2 random with sample 5 = 0xAA.
  task automatic run_frame(input int nsamp, input bit mark_last, input int valid_pct,
                           input int hold, input int mode);
    logic [DW-1:0] d[N];
    bit bad_end;
    int i;
    int guard;
    bit v;
    for (int k = 0; k < N; k++) d[k] = (mode == 1) ? DW'(k) : DW'($urandom);
    if (mode == 2) d[5] = 8'hAA;
    bad_end = (nsamp < N) || !mark_last;
    i = 0;
    guard = 0;
    while (i < nsamp) begin
      v = ($urandom_range(99) < valid_pct);
      bus.in_valid  = v;
      bus.in_data   = v ? d[i] : DW'($urandom);
      bus.in_last   = v ? ((i == nsamp - 1) && (nsamp < N || mark_last)) : 1'($urandom);
      bus.frame_ack = 1'($urandom);
      #1;
      check_val("fill_ready", 32'(bus.in_ready), 1);
      tick();
      if (v) begin
        check_write("fill_wr", rev(i), int'(d[i]));
        check_val("fill_err", 32'(bus.frame_err), 32'((i == nsamp - 1) && bad_end));
        if (mode == 1 && (i == 1 || i == 3))
          check_val("seq_addr", 32'(bus.mem_addr), 32'(i == 1 ? 8 : 12));
        i++;
      end else begin
        check_idle("gap");
        check_val("gap_err", 32'(bus.frame_err), 0);
      end
      check_val("fill_fv", 32'(bus.frame_valid), 0);
      guard++;
      if (guard > 2000) begin
        check_val("fill_timeout", 32'(guard), 0);
        i = nsamp;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int j = nsamp; j < N; j++) begin
      bus.frame_ack = 1'($urandom);
      #1;
      check_val("pad_ready", 32'(bus.in_ready), 0);
      tick();
      check_write("pad_wr", rev(j), 0);
      check_val("pad_err", 32'(bus.frame_err), 0);
      check_val("pad_fv", 32'(bus.frame_valid), 0);
    end
    bus.frame_ack = 1'b0;
    #1;
    check_val("last_wr_ready", 32'(bus.in_ready), 0);
    tick();
    check_val("fv_rise", 32'(bus.frame_valid), 1);
    check_idle("hold");
    for (int h = 0; h < hold; h++) begin
      tick();
      check_val("hold_fv", 32'(bus.frame_valid), 1);
      check_val("hold_ready", 32'(bus.in_ready), 0);
      check_val("hold_err", 32'(bus.frame_err), 0);
      check_idle("hold");
    end
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    #1;
    check_val("ack_fv", 32'(bus.frame_valid), 0);
    check_val("ack_ready", 32'(bus.in_ready), 1);
    check_idle("ack");
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.frame_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("rst_ready", 32'(bus.in_ready), 0);
    end
    check_reset_outputs();
    reset = 1'b0;
    #1;
    check_val("post_rst_ready", 32'(bus.in_ready), 1);

    run_frame(16, 1'b1, 100, 5, 1);
    run_frame(6, 1'b1, 100, 0, 2);
    run_frame(1, 1'b1, 100, 2, 0);
    run_frame(16, 1'b0, 100, 1, 0);
    for (int f = 0; f < 4; f++) run_frame(16, 1'b1, 50, $urandom_range(3), 0);
    for (int f = 0; f < 3; f++) run_frame($urandom_range(1, 16), 1'b1, 50, $urandom_range(3), 0);

    // Abort a frame after 7 samples, then a clean full frame.
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(i + 8'h30);
      bus.in_last  = 1'b0;
      tick();
      check_write("abort_wr", rev(i), i + 8'h30);
    end
    reset = 1'b1;
    #1;
    check_val("abort_rst_ready", 32'(bus.in_ready), 0);
    tick();
    check_reset_outputs();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_val("abort_ready", 32'(bus.in_ready), 1);
    run_frame(16, 1'b1, 100, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fantasticfft_input_loader.md
# fantasticfft_input_loader

Upstream stage of the FFT sample RAM. It accepts a stream of time-domain samples over a valid/ready handshake and writes each frame of N samples into the RAM at bit-reversed addresses, so the FFT core can run in-place decimation-in-time passes directly. When the frame is complete it signals the FFT core and holds off new input until the core acknowledges. Early or missing frame-end markers are flagged, and a short frame is zero-padded.

## Interface
- DATA_WIDTH, 8: sample width; matches the RAM data width.
- LOG2_N, 4: log2 of the frame length; N = 2**LOG2_N = 16.
- ADDR_WIDTH, 16: RAM address width; must be ≥ LOG2_N. Upper bits are driven 0.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  loader can accept a sample this cycle.
- in_data  in  DATA_WIDTH  sample value.
- in_last  in  1  marks the final sample of a frame.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_read_write  out  1  1 = write cycle, 0 = idle/read.
- mem_wdata  out  DATA_WIDTH  write data. The top level drives it onto the RAM data bus when mem_drive = 1.
- mem_drive  out  1  tristate enable for the bus; always equal to mem_read_write.
- frame_valid  out  1  complete frame is resident in RAM.
- frame_ack  in  1  FFT core has taken ownership of the frame.
- frame_err  out  1  one-cycle pulse on a framing error.

## Operation
- States: FILL, PAD, HOLD.
- Index counter idx has LOG2_N bits. Write address = bitrev(idx), zero-extended to ADDR_WIDTH.
- **FILL**
  - in_ready = 1.
  - On in_valid & in_ready, register a write of in_data at bitrev(idx).
  - If idx = N-1: go to HOLD. If in_last = 0, also pulse frame_err.
  - If idx < N-1 and in_last = 1: pulse frame_err and go to PAD with idx+1.
  - Otherwise idx increments.
- **PAD**
  - in_ready = 0.
  - Write 0 at bitrev(idx) on each cycle, one per cycle, through idx = N-1, then go to HOLD.
- **HOLD**
  - in_ready = 0, no writes, frame_valid = 1.
  - frame_ack = 1 means: next cycle frame_valid = 0, idx = 0, state FILL.
  - frame_ack is ignored outside HOLD.
- **Reset**
  - A frame in progress is discarded. No frame_valid is raised for it.
  - The RAM contents are not touched.
- mem_wdata and mem_addr hold their last value when mem_read_write = 0.

## Timing
- All outputs are registered except in_ready, which is decoded from state.
- Reset values:
  - in_ready 0 during reset; 1 on the first cycle after reset deasserts.
  - mem_addr 0, mem_read_write 0, mem_drive 0, mem_wdata 0.
  - frame_valid 0, frame_err 0.
  - Internal: state FILL, idx 0.
- Write latency: a sample accepted in cycle k appears as a write (mem_read_write = 1) in cycle k+1.
- Throughput: 1 sample/cycle with no bubbles within a frame.
- in_ready falls combinationally in the cycle after the frame's last accepted sample.
- frame_valid rises in the cycle after the final write cycle (normal or pad).
- An ack asserted in the first cycle of frame_valid is honoured.
- Minimum frame-to-frame gap: the ack cycle plus 1 cycle before in_ready = 1.
- frame_err pulses in the cycle after the offending acceptance, concurrent with that sample's write.
- An early in_last on idx = 0 produces N-1 pad writes.

## Structure
- Package fantasticfft_pkg holds:
  - typedef enum for the loader states (FILL, PAD, HOLD);
  - a bitrev function parameterised by width;
  - default constants DATA_WIDTH = 8, LOG2_N = 4.
- One sub-module, fantasticfft_bitrev: combinational, parameter WIDTH, in/out WIDTH. It is instantiated once on the idx path.
- The tristate buffer stays in the top level; the loader only provides mem_wdata and mem_drive.

## Test plan
- Reset, then stream samples 0..15 back-to-back with in_last on the 16th.
  - Write at cycle k+1 for each accepted sample.
  - Sample 1 goes to address 8 and sample 3 to address 12.
  - frame_valid rises 1 cycle after the write of sample 15 to address 15.
  - frame_err is never asserted.
- Hold frame_valid for 5 cycles, then pulse frame_ack.
  - in_ready = 0 throughout the hold.
  - in_ready = 1 in the cycle after the ack.
  - The next sample is written to address 0.
- Early in_last on the sample at idx 5 (value 0xAA).
  - 0xAA is written at address 10.
  - frame_err pulses once.
  - Zeros are written at bitrev(6..15), i.e. addresses 6, 14, 1, 9, …, 15, on consecutive cycles.
  - frame_valid then rises.
- 16 samples with in_last never asserted: frame_err pulses with the write of idx 15, and the frame completes normally.
- Random in_valid gaps (50% duty): address/data pairing still matches the bit-reversed order, and no write occurs in gap cycles.
- Reset asserted after 7 samples: the next cycle has all outputs at their reset values, and a following full frame is written from address 0 with correct completion.
